// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller states, forwarding-mux select codes and the counter saturation helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // Select codes line up with inputs A-D of four_to_one_multiplexer.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // True while a counter of the given width (1..64) is below all-ones.
  function automatic logic sat_can_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = {64{1'b1}} >> (64 - width);
    return value != max_val;
  endfunction

endpackage

// File: rtl/hazard_forwarding_unit_forwarding_select.sv
// Maps one ID-stage source register to a forwarding-mux select.
// Priority is EX > MEM > WB > register file; x0 is never forwarded.
module forwarding_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       ex_fwd_ok,
  input  logic       mem_we,
  input  logic       wb_we,
  output logic [1:0] sel
);

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (ex_fwd_ok && (ex_rd == rs))      sel = FWD_EX;
      else if (mem_we && (mem_rd == rs))   sel = FWD_MEM;
      else if (wb_we && (wb_rd == rs))     sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Five-stage pipeline hazard controller: stall/squash/freeze decisions, operand
// forwarding selects, data-RAM wait sequencing with timeout, and performance counters.
module hazard_forwarding_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic [4:0]       MEM_rd,
  input  logic [4:0]       WB_rd,
  input  logic             EX_RF_Enable,
  input  logic             MEM_RF_Enable,
  input  logic             WB_RF_Enable,
  input  logic             EX_Load_Instr,
  input  logic             EX_Branch_Taken,
  input  logic             MEM_RAM_Enable,
  input  logic             mem_ready,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             idex_le,
  output logic             exmem_le,
  output logic             ifid_clr,
  output logic             memwb_clr,
  output logic             cu_mux_sel,
  output logic [1:0]       fwd_A_sel,
  output logic [1:0]       fwd_B_sel,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              err_set;
  logic              mem_freeze;
  logic              load_use;
  logic              flush_cycle;

  // A load result is not available in EX, so a load there is never a forwarding source.
  forwarding_select u_fwd_a (
    .rs        (ID_rs1),
    .ex_rd     (EX_rd),
    .mem_rd    (MEM_rd),
    .wb_rd     (WB_rd),
    .ex_fwd_ok (EX_RF_Enable && !EX_Load_Instr),
    .mem_we    (MEM_RF_Enable),
    .wb_we     (WB_RF_Enable),
    .sel       (fwd_A_sel)
  );

  forwarding_select u_fwd_b (
    .rs        (ID_rs2),
    .ex_rd     (EX_rd),
    .mem_rd    (MEM_rd),
    .wb_rd     (WB_rd),
    .ex_fwd_ok (EX_RF_Enable && !EX_Load_Instr),
    .mem_we    (MEM_RF_Enable),
    .wb_we     (WB_RF_Enable),
    .sel       (fwd_B_sel)
  );

  assign mem_freeze = (state == ST_MEM_WAIT) ||
                      ((state == ST_RUN) && MEM_RAM_Enable && !mem_ready);

  assign load_use = EX_Load_Instr && EX_RF_Enable && (EX_rd != 5'd0) &&
                    ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_uses_rs2 && (ID_rs2 == EX_rd)));

  // Pipeline control: first matching condition wins; the defaults are free flow.
  always_comb begin
    pc_le       = 1'b1;
    ifid_le     = 1'b1;
    idex_le     = 1'b1;
    exmem_le    = 1'b1;
    ifid_clr    = 1'b0;
    memwb_clr   = 1'b0;
    cu_mux_sel  = 1'b0;
    flush_cycle = 1'b0;
    if (!reset_n) begin
      {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
      {ifid_clr, memwb_clr, cu_mux_sel}   = 3'b111;
    end else if ((state == ST_HALT) || mem_freeze) begin
      {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
      memwb_clr = 1'b1;
    end else if (EX_Branch_Taken) begin
      ifid_clr    = 1'b1;
      cu_mux_sel  = 1'b1;
      flush_cycle = 1'b1;
    end else if (load_use) begin
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      cu_mux_sel = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    err_set    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (MEM_RAM_Enable && !mem_ready) begin
          state_n    = ST_MEM_WAIT;
          wait_cnt_n = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_n = ST_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = ST_HALT;
          err_set = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (err_set) mem_error <= 1'b1;
      if (!pc_le && sat_can_inc(64'(stall_count), CNT_W))
        stall_count <= stall_count + 1'b1;
      if (flush_cycle && sat_can_inc(64'(flush_count), CNT_W))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
